bkm_data_step_checker: RTL

- Scoreboard stage directly downstream of the bkm_data_step monitor.
- Consumes the monitor's binary results (res_X_np1, res_Y_np1) and compares them in order against expected values queued by the reference model.
- Keeps pass/fail counters, captures the first mismatch, and flags queue overflow/underflow for the bkm_data_step bench.

---
 rtl/bkm_data_step_checker.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/bkm_data_step_checker.sv
// In-order scoreboard for bkm_data_step results: expected pairs queue in a FIFO
// and are compared against monitor observations, with counters, first-error capture and sticky flags.
module bkm_data_step_checker #(
  parameter int W           = 64,
  parameter int DEPTH       = 16,
  parameter int CW          = 16,
  parameter int HALT_ON_ERR = 0
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic                     srst,
  input  logic                     enable,
  input  logic                     exp_valid,
  input  logic [W-1:0]             exp_X,
  input  logic [W-1:0]             exp_Y,
  input  logic                     obs_valid,
  input  logic [W-1:0]             res_X_np1,
  input  logic [W-1:0]             res_Y_np1,
  output logic [CW-1:0]            n_checked,
  output logic [CW-1:0]            n_errors,
  output logic                     err_valid,
  output logic [W-1:0]             err_X_exp,
  output logic [W-1:0]             err_X_obs,
  output logic [W-1:0]             err_Y_exp,
  output logic [W-1:0]             err_Y_obs,
  output logic                     mismatch,
  output logic                     overflow,
  output logic                     underflow,
  output logic                     halted,
  output logic [$clog2(DEPTH):0]   fifo_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  typedef enum logic {S_RUN, S_HALT} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic [CW-1:0]   n_checked_q, n_checked_d, n_errors_q, n_errors_d;
  logic            err_valid_q, err_valid_d;
  logic [W-1:0]    err_x_exp_q, err_x_exp_d, err_x_obs_q, err_x_obs_d;
  logic [W-1:0]    err_y_exp_q, err_y_exp_d, err_y_obs_q, err_y_obs_d;
  logic            mismatch_q, mismatch_d;
  logic            overflow_q, overflow_d, underflow_q, underflow_d;

  logic [2*W-1:0]  fifo_mem [DEPTH];
  logic [2*W-1:0]  head;
  logic            run, fifo_empty, fifo_full;
  logic            do_pop, bypass, push_req, do_push, do_cmp, is_mis;
  logic [W-1:0]    cmp_x, cmp_y;

  always_comb begin
    run        = enable && (state_q == S_RUN);
    fifo_empty = (cnt_q == '0);
    fifo_full  = (cnt_q == FULL_CNT);
    head       = fifo_mem[rd_ptr_q];

    // An empty FIFO with a same-cycle expected value compares directly (bypass)
    do_pop   = run && obs_valid && !fifo_empty;
    bypass   = run && obs_valid && fifo_empty && exp_valid;
    push_req = run && exp_valid && !bypass;
    do_push  = push_req && (!fifo_full || do_pop);
    do_cmp   = do_pop || bypass;
    cmp_x    = do_pop ? head[2*W-1:W] : exp_X;
    cmp_y    = do_pop ? head[W-1:0]   : exp_Y;
    is_mis   = do_cmp && ((cmp_x != res_X_np1) || (cmp_y != res_Y_np1));

    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    n_checked_d = n_checked_q;
    n_errors_d  = n_errors_q;
    err_valid_d = err_valid_q;
    err_x_exp_d = err_x_exp_q;
    err_x_obs_d = err_x_obs_q;
    err_y_exp_d = err_y_exp_q;
    err_y_obs_d = err_y_obs_q;
    mismatch_d  = is_mis;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop) cnt_d = cnt_q + (AW+1)'(1);
    if (do_pop && !do_push) cnt_d = cnt_q - (AW+1)'(1);

    if (push_req && fifo_full && !do_pop) overflow_d = 1'b1;
    if (run && obs_valid && fifo_empty && !exp_valid) underflow_d = 1'b1;

    if (do_cmp && (n_checked_q != CNT_MAX)) n_checked_d = n_checked_q + CW'(1);
    if (is_mis && (n_errors_q != CNT_MAX))  n_errors_d  = n_errors_q + CW'(1);

    if (is_mis && !err_valid_q) begin
      err_valid_d = 1'b1;
      err_x_exp_d = cmp_x;
      err_x_obs_d = res_X_np1;
      err_y_exp_d = cmp_y;
      err_y_obs_d = res_Y_np1;
    end

    if (is_mis && (HALT_ON_ERR != 0)) state_d = S_HALT;
  end

  always_ff @(posedge clk) begin
    if (do_push) fifo_mem[wr_ptr_q] <= {exp_X, exp_Y};
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q     <= S_RUN;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      n_checked_q <= '0;
      n_errors_q  <= '0;
      err_valid_q <= 1'b0;
      err_x_exp_q <= '0;
      err_x_obs_q <= '0;
      err_y_exp_q <= '0;
      err_y_obs_q <= '0;
      mismatch_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (srst) begin
      state_q     <= S_RUN;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      n_checked_q <= '0;
      n_errors_q  <= '0;
      err_valid_q <= 1'b0;
      err_x_exp_q <= '0;
      err_x_obs_q <= '0;
      err_y_exp_q <= '0;
      err_y_obs_q <= '0;
      mismatch_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      n_checked_q <= n_checked_d;
      n_errors_q  <= n_errors_d;
      err_valid_q <= err_valid_d;
      err_x_exp_q <= err_x_exp_d;
      err_x_obs_q <= err_x_obs_d;
      err_y_exp_q <= err_y_exp_d;
      err_y_obs_q <= err_y_obs_d;
      mismatch_q  <= mismatch_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign n_checked = n_checked_q;
  assign n_errors  = n_errors_q;
  assign err_valid = err_valid_q;
  assign err_X_exp = err_x_exp_q;
  assign err_X_obs = err_x_obs_q;
  assign err_Y_exp = err_y_exp_q;
  assign err_Y_obs = err_y_obs_q;
  assign mismatch  = mismatch_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign halted    = (state_q == S_HALT);
  assign fifo_cnt  = cnt_q;

endmodule
